// File: rtl/pll_cfg_supervisor.sv
// iCE40 PLL supervisor: reset sequencing, filtered lock with timeout/retry, serial config shift (optional PLL_AUTO_RELOCK_EN).
// Lock sync adds 2 cycles; cfg requests are accepted only in LOCKED/FAIL (cfg_ready), never queued.
module pll_cfg_supervisor #(
  parameter int CFG_W        = 26,
  parameter int SCLK_DIV     = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RETRY    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CFG_W-1:0]                 cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic [CFG_W-1:0]                 cfg_readback,
  output logic                             pll_resetb,
  output logic                             pll_bypass,
  output logic                             pll_sclk,
  output logic                             pll_sdi,
  input  logic                             pll_sdo,
  input  logic                             pll_lock,
  output logic                             locked,
  output logic                             busy,
  output logic                             err,
  output logic [$clog2(MAX_RETRY+1):0]     retry_cnt
);

  localparam int RCW = $clog2(MAX_RETRY+1) + 1;
  localparam int RW  = $clog2(RST_CYCLES+1);
  localparam int TW  = $clog2(LOCK_TIMEOUT+1);
  localparam int FW  = $clog2(LOCK_FILT+1);
  localparam int DW  = $clog2(SCLK_DIV+1);
  localparam int BW  = $clog2(CFG_W+1);

  localparam logic [RW-1:0]  RST_LAST  = RW'(RST_CYCLES-1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TIMEOUT-1);
  localparam logic [FW-1:0]  FILT_LAST = FW'(LOCK_FILT-1);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(SCLK_DIV-1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(CFG_W-1);
  localparam logic [RCW-1:0] RETRY_LIM = RCW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    LOCKED,
    FAIL,
    SHIFT
  } state_t;

  state_t           state;
  logic [RW-1:0]    rst_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [FW-1:0]    filt_cnt;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [CFG_W-1:0] wr_sh;
  logic [CFG_W-1:0] rd_sh;
  logic             lock_m;
  logic             lock_s;
  logic [RCW-1:0]   retry_inc;
  logic             accept;

  assign retry_inc = retry_cnt + RCW'(1);
  assign accept    = cfg_valid && cfg_ready;

  // LOCK from a PLL held in reset is meaningless, so the synchroniser restarts with each attempt.
  always_ff @(posedge clk) begin
    if (reset || !pll_resetb) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RESET_HOLD;
      rst_cnt      <= '0;
      tmo_cnt      <= '0;
      filt_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      wr_sh        <= '0;
      rd_sh        <= '0;
      pll_resetb   <= 1'b0;
      pll_bypass   <= 1'b1;
      pll_sclk     <= 1'b0;
      pll_sdi      <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b1;
      err          <= 1'b0;
      cfg_ready    <= 1'b0;
      cfg_readback <= '0;
      retry_cnt    <= '0;
    end else if (accept) begin
      state      <= SHIFT;
      wr_sh      <= {cfg_data[CFG_W-2:0], 1'b0};
      pll_sdi    <= cfg_data[CFG_W-1];
      rd_sh      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      pll_sclk   <= 1'b0;
      pll_resetb <= 1'b0;
      pll_bypass <= 1'b1;
      locked     <= 1'b0;
      err        <= 1'b0;
      retry_cnt  <= '0;
      cfg_ready  <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (rst_cnt == RST_LAST) begin
            rst_cnt    <= '0;
            pll_resetb <= 1'b1;
            pll_bypass <= 1'b0;
            state      <= WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        WAIT_LOCK: begin
          // Lock is tested first so that a filter/timeout tie resolves to LOCKED.
          if (lock_s && filt_cnt == FILT_LAST) begin
            tmo_cnt   <= '0;
            filt_cnt  <= '0;
            locked    <= 1'b1;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            retry_cnt <= '0;
            state     <= LOCKED;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt    <= '0;
            filt_cnt   <= '0;
            pll_resetb <= 1'b0;
            pll_bypass <= 1'b1;
            retry_cnt  <= retry_inc;
            if (retry_inc > RETRY_LIM) begin
              err       <= 1'b1;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
              state     <= FAIL;
            end else begin
              state <= RESET_HOLD;
            end
          end else begin
            tmo_cnt  <= tmo_cnt + TW'(1);
            filt_cnt <= lock_s ? filt_cnt + FW'(1) : '0;
          end
        end

        LOCKED: begin
          if (!lock_s) begin
            locked     <= 1'b0;
            pll_resetb <= 1'b0;
            pll_bypass <= 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
            retry_cnt  <= '0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= RESET_HOLD;
`else
            err        <= 1'b1;
            state      <= FAIL;
`endif
          end
        end

        FAIL: begin
          locked     <= 1'b0;
          pll_resetb <= 1'b0;
          pll_bypass <= 1'b1;
        end

        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!pll_sclk) begin
              pll_sclk <= 1'b1;
              rd_sh    <= {rd_sh[CFG_W-2:0], pll_sdo};
            end else begin
              pll_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt      <= '0;
                pll_sdi      <= 1'b0;
                cfg_readback <= rd_sh;
                state        <= RESET_HOLD;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                pll_sdi <= wr_sh[CFG_W-1];
                wr_sh   <= {wr_sh[CFG_W-2:0], 1'b0};
              end
            end
          end
        end

        default: begin
          state      <= RESET_HOLD;
          pll_resetb <= 1'b0;
          pll_bypass <= 1'b1;
          busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_supervisor.sv
// Self-checking bench for pll_cfg_supervisor: reset, power-up, glitch, retry, config shift, abort, lock loss.
module tb_pll_cfg_supervisor;
  localparam int CFG_W        = 26;
  localparam int SCLK_DIV     = 2;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_FILT    = 8;
  localparam int LOCK_TIMEOUT = 1000;
  localparam int MAX_RETRY    = 2;
  localparam int RCW          = $clog2(MAX_RETRY+1) + 1;
  localparam int SHIFT_CYC    = CFG_W * 2 * SCLK_DIV;
  localparam int LOCK_LAT     = 2 + LOCK_FILT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CFG_W-1:0] cfg_data = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_readback;
  logic             pll_resetb, pll_bypass, pll_sclk, pll_sdi;
  logic             pll_sdo;
  logic             pll_lock = 1'b0;
  logic             locked, busy, err;
  logic [RCW-1:0]   retry_cnt;
  logic             loop_en = 1'b0;

  int tests = 0;
  int fails = 0;

  bit               exp_bits[$];
  logic [CFG_W-1:0] exp_rb[$];
  int               exp_retry[$];
  int               exp_at[$];

  assign pll_sdo = loop_en ? pll_sdi : 1'b0;

  always #5 clk = ~clk;

  pll_cfg_supervisor #(
    .CFG_W(CFG_W), .SCLK_DIV(SCLK_DIV), .RST_CYCLES(RST_CYCLES),
    .LOCK_FILT(LOCK_FILT), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_readback(cfg_readback),
    .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .pll_sclk(pll_sclk),
    .pll_sdi(pll_sdi), .pll_sdo(pll_sdo), .pll_lock(pll_lock),
    .locked(locked), .busy(busy), .err(err), .retry_cnt(retry_cnt)
  );

  task automatic start_seq(input logic lk);
    reset = 1'b1; pll_lock = lk; cfg_valid = 1'b0; loop_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_resetb(output int n);
    n = 0;
    while (!pll_resetb && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (!locked && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({pll_resetb, pll_bypass, pll_sclk, pll_sdi, locked, busy, err, cfg_ready} !== 8'b0100_0100) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 01000100",
               {pll_resetb, pll_bypass, pll_sclk, pll_sdi, locked, busy, err, cfg_ready});
    end
    tests++;
    if (cfg_readback !== '0 || retry_cnt !== '0) begin
      fails++;
      $display("FAIL reset_regs: readback %h retry %0d want 0/0", cfg_readback, retry_cnt);
    end
  endtask

  task automatic test_powerup;
    int n;
    int bad;
    start_seq(1'b1);
    wait_resetb(n);
    tests++;
    if (n !== RST_CYCLES) begin fails++; $display("FAIL powerup_resetb: rose after %0d want %0d", n, RST_CYCLES); end
    tests++;
    if (pll_bypass !== 1'b0) begin fails++; $display("FAIL powerup_bypass: got %b want 0", pll_bypass); end
    wait_locked(n);
    tests++;
    if (n !== LOCK_LAT) begin fails++; $display("FAIL powerup_locked: rose after %0d want %0d", n, LOCK_LAT); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || err !== 1'b0 || locked !== 1'b1 || cfg_ready !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL powerup_steady: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_glitch;
    int n;
    start_seq(1'b0);
    wait_resetb(n);
    pll_lock = 1'b1;
    repeat (7) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL glitch_early: locked %b want 0", locked); end
    wait_locked(n);
    tests++;
    if (n !== LOCK_LAT) begin fails++; $display("FAIL glitch_relock: rose after %0d want %0d", n, LOCK_LAT); end
  endtask

  task automatic test_retry;
    int n;
    int exp_v;
    int exp_n;
    logic [RCW-1:0] prev;
    start_seq(1'b0);
    for (int k = 1; k <= MAX_RETRY + 1; k++) begin
      exp_retry.push_back(k);
      exp_at.push_back(k * (RST_CYCLES + LOCK_TIMEOUT));
    end
    prev = '0;
    n = 0;
    while (n < (MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT) + 50 && !(exp_retry.size() == 0 && err)) begin
      @(negedge clk);
      n++;
      if (retry_cnt !== prev) begin
        prev = retry_cnt;
        tests++;
        if (exp_retry.size() == 0) begin
          fails++; $display("FAIL retry_step: unexpected retry_cnt %0d at cycle %0d", retry_cnt, n);
        end else begin
          exp_v = exp_retry.pop_front();
          exp_n = exp_at.pop_front();
          if (int'(retry_cnt) != exp_v || n != exp_n || pll_resetb !== 1'b0) begin
            fails++;
            $display("FAIL retry_step: got %0d at %0d resetb %b want %0d at %0d resetb 0",
                     retry_cnt, n, pll_resetb, exp_v, exp_n);
          end
        end
      end
    end
    tests++;
    if (exp_retry.size() != 0) begin
      fails++; $display("FAIL retry_timeout: %0d steps missing want 0", exp_retry.size());
      exp_retry.delete(); exp_at.delete();
    end
    repeat (5) @(negedge clk);
    tests++;
    if ({err, locked, pll_resetb, busy, cfg_ready} !== 5'b10001) begin
      fails++; $display("FAIL retry_fail_state: got %b want 10001", {err, locked, pll_resetb, busy, cfg_ready});
    end
    cfg_data = 26'h155_AA55;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    tests++;
    if ({err, busy, cfg_ready} !== 3'b010 || retry_cnt !== '0) begin
      fails++; $display("FAIL fail_accept: err/busy/ready %b retry %0d want 010/0", {err, busy, cfg_ready}, retry_cnt);
    end
  endtask

  task automatic test_ignored;
    int n;
    int bad;
    start_seq(1'b0);
    @(negedge clk);
    cfg_data = 26'h3FF_FFFF;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    bad = 0;
    n = 2;
    while (!pll_resetb && n < 100) begin
      @(negedge clk); n++;
      if (pll_sclk !== 1'b0 || cfg_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || n != RST_CYCLES) begin
      fails++; $display("FAIL ignored_req: %0d bad cycles, resetb at %0d want 0, %0d", bad, n, RST_CYCLES);
    end
  endtask

  task automatic test_cfg_shift;
    int n;
    int rises;
    logic prev_sclk;
    bit b;
    logic [CFG_W-1:0] rb;
    start_seq(1'b1);
    wait_locked(n);
    loop_en = 1'b1;
    cfg_data = 26'h2A5_5A5A;
    for (int i = CFG_W - 1; i >= 0; i--) exp_bits.push_back(cfg_data[i]);
    exp_rb.push_back(cfg_data);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    tests++;
    if ({busy, cfg_ready, locked, pll_resetb, pll_bypass} !== 5'b10001) begin
      fails++; $display("FAIL shift_enter: got %b want 10001", {busy, cfg_ready, locked, pll_resetb, pll_bypass});
    end
    rises = 0;
    prev_sclk = pll_sclk;
    for (int c = 1; c <= SHIFT_CYC; c++) begin
      @(negedge clk);
      if (pll_sclk && !prev_sclk) begin
        rises++;
        tests++;
        if (exp_bits.size() == 0) begin
          fails++; $display("FAIL shift_bit: extra sclk rise %0d", rises);
        end else begin
          b = exp_bits.pop_front();
          if (pll_sdi !== b) begin fails++; $display("FAIL shift_bit: bit %0d got %b want %b", rises, pll_sdi, b); end
        end
      end
      prev_sclk = pll_sclk;
      if (c == SHIFT_CYC - 1) begin
        tests++;
        if (cfg_readback !== '0) begin fails++; $display("FAIL shift_early: readback %h want 0", cfg_readback); end
      end
    end
    rb = exp_rb.pop_front();
    tests++;
    if (cfg_readback !== rb || pll_sclk !== 1'b0 || pll_sdi !== 1'b0 || rises != CFG_W) begin
      fails++;
      $display("FAIL shift_done: rb %h sclk %b sdi %b rises %0d want %h 0 0 %0d",
               cfg_readback, pll_sclk, pll_sdi, rises, rb, CFG_W);
    end
    exp_bits.delete();
    wait_locked(n);
    tests++;
    if (n !== RST_CYCLES + LOCK_LAT) begin
      fails++; $display("FAIL shift_relock: locked after %0d want %0d", n, RST_CYCLES + LOCK_LAT);
    end
  endtask

  task automatic test_reset_mid_shift;
    int n;
    int rises;
    logic prev_sclk;
    cfg_data = 26'h3C0_F00F;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    rises = 0; n = 0;
    prev_sclk = pll_sclk;
    while (rises < 10 && n < 200) begin
      @(negedge clk); n++;
      if (pll_sclk && !prev_sclk) rises++;
      prev_sclk = pll_sclk;
    end
    tests++;
    if (rises != 10) begin fails++; $display("FAIL abort_reach: rises %0d want 10", rises); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({pll_sclk, busy, pll_resetb, pll_bypass, cfg_ready, locked} !== 6'b010100 || cfg_readback !== '0) begin
      fails++;
      $display("FAIL abort_state: flags %b readback %h want 010100 0",
               {pll_sclk, busy, pll_resetb, pll_bypass, cfg_ready, locked}, cfg_readback);
    end
    reset = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic test_lock_loss;
    int n;
    start_seq(1'b1);
    wait_locked(n);
    pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL loss_sync: locked %b want 1", locked); end
    @(negedge clk);
`ifdef PLL_AUTO_RELOCK_EN
    tests++;
    if ({locked, err, busy, pll_resetb} !== 4'b0010) begin
      fails++; $display("FAIL loss_relock_enter: got %b want 0010", {locked, err, busy, pll_resetb});
    end
    pll_lock = 1'b1;
    wait_locked(n);
    tests++;
    if (n !== RST_CYCLES + LOCK_LAT || err !== 1'b0) begin
      fails++; $display("FAIL loss_relock: after %0d err %b want %0d 0", n, err, RST_CYCLES + LOCK_LAT);
    end
`else
    tests++;
    if ({locked, err, pll_resetb, busy, cfg_ready} !== 5'b01001) begin
      fails++; $display("FAIL loss_fail: got %b want 01001", {locked, err, pll_resetb, busy, cfg_ready});
    end
    pll_lock = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if ({locked, err, pll_resetb} !== 3'b010) begin
      fails++; $display("FAIL loss_hold: got %b want 010", {locked, err, pll_resetb});
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_powerup();
    test_glitch();
    test_retry();
    test_ignored();
    test_cfg_shift();
    test_reset_mid_shift();
    test_lock_loss();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
